// File: rtl/calc_sequencer_if.sv
// Key/ALU handshake bundle between the calculator keypad front end and the sequencer.
// Signal order follows the block's port list.
interface calc_sequencer_if;
   logic       key_valid;
   logic [4:0] key_code;
   logic       alu_done;
   logic       store_digit;
   logic [3:0] digit;
   logic       is_reg;
   logic [2:0] reg_sel;
   logic       reg_wen;
   logic [1:0] alu_op;
   logic       alu_start;
   logic       result_ready;
   logic       busy;
   logic       error;

   modport master (
      output key_valid, key_code, alu_done,
      input  store_digit, digit, is_reg, reg_sel, reg_wen, alu_op,
             alu_start, result_ready, busy, error
   );

   modport slave (
      input  key_valid, key_code, alu_done,
      output store_digit, digit, is_reg, reg_sel, reg_wen, alu_op,
             alu_start, result_ready, busy, error
   );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: turns key strobes into operand-buffer, register-file
// and ALU control pulses. Every output is registered one cycle after its cause.
module calc_sequencer (
   input logic             clk,
   input logic             rst,
   calc_sequencer_if.slave bus
);

   typedef enum logic [2:0] {ENTRY, WAIT_REG, EXEC, WAIT_ALU, DONE, ERR} state_t;
   typedef enum logic [1:0] {OP_NONE, OP_LOAD, OP_ADD, OP_SUB} pend_t;

   state_t     state_q, state_d;
   pend_t      pend_q, pend_d;
   logic [1:0] dcnt_q, dcnt_d;
   logic [3:0] tcnt_q, tcnt_d;
   logic       store_digit_q, store_digit_d;
   logic [3:0] digit_q, digit_d;
   logic       is_reg_q, is_reg_d;
   logic [2:0] reg_sel_q, reg_sel_d;
   logic       reg_wen_q, reg_wen_d;
   logic [1:0] alu_op_q, alu_op_d;
   logic       alu_start_q, alu_start_d;
   logic       result_ready_q, result_ready_d;
   logic       busy_q, busy_d;
   logic       error_q, error_d;

   logic k_digit, k_load, k_add, k_sub, k_clear, k_reg, k_illegal;

   assign k_digit   = bus.key_valid & ~bus.key_code[4];
   assign k_load    = bus.key_valid & (bus.key_code == 5'h10);
   assign k_add     = bus.key_valid & (bus.key_code == 5'h11);
   assign k_sub     = bus.key_valid & (bus.key_code == 5'h12);
   assign k_clear   = bus.key_valid & (bus.key_code == 5'h14);
   assign k_reg     = bus.key_valid & (bus.key_code[4:3] == 2'b11);
   assign k_illegal = bus.key_valid & ~(k_digit | k_load | k_add | k_sub | k_clear | k_reg);

   always_comb begin
      state_d        = state_q;
      pend_d         = pend_q;
      dcnt_d         = dcnt_q;
      tcnt_d         = tcnt_q;
      store_digit_d  = 1'b0;
      digit_d        = digit_q;
      is_reg_d       = 1'b0;
      reg_sel_d      = reg_sel_q;
      reg_wen_d      = 1'b0;
      alu_op_d       = alu_op_q;
      alu_start_d    = 1'b0;
      result_ready_d = 1'b0;

      case (state_q)
         ENTRY: begin
            if (k_digit) begin
               // Operand buffer holds two digits; extra digits are dropped silently.
               if (dcnt_q < 2'd2) begin
                  store_digit_d = 1'b1;
                  digit_d       = bus.key_code[3:0];
                  dcnt_d        = dcnt_q + 2'd1;
               end
            end else if (k_load) begin
               pend_d  = OP_LOAD;
               state_d = WAIT_REG;
            end else if (k_add) begin
               pend_d   = OP_ADD;
               alu_op_d = 2'b00;
               state_d  = WAIT_REG;
            end else if (k_sub) begin
               pend_d   = OP_SUB;
               alu_op_d = 2'b01;
               state_d  = WAIT_REG;
            end else if (k_clear) begin
               is_reg_d = 1'b1;
               dcnt_d   = 2'd0;
               pend_d   = OP_NONE;
            end else if (k_reg | k_illegal) begin
               state_d = ERR;
            end
         end
         WAIT_REG: begin
            if (k_clear) begin
               is_reg_d = 1'b1;
               dcnt_d   = 2'd0;
               pend_d   = OP_NONE;
               state_d  = ENTRY;
            end else if (k_reg) begin
               reg_sel_d = bus.key_code[2:0];
               if (pend_q == OP_LOAD) begin
                  reg_wen_d = 1'b1;
                  is_reg_d  = 1'b1;
                  dcnt_d    = 2'd0;
                  pend_d    = OP_NONE;
                  state_d   = ENTRY;
               end else begin
                  state_d = EXEC;
               end
            end else if (bus.key_valid) begin
               state_d = ERR;
            end
         end
         EXEC: begin
            alu_start_d = 1'b1;
            tcnt_d      = 4'd0;
            state_d     = WAIT_ALU;
         end
         WAIT_ALU: begin
            if (bus.alu_done) begin
               result_ready_d = 1'b1;
               dcnt_d         = 2'd0;
               pend_d         = OP_NONE;
               state_d        = DONE;
            end else begin
               // Sixteenth silent cycle wraps the counter and abandons the operation.
               tcnt_d = tcnt_q + 4'd1;
               if (tcnt_q == 4'hF) state_d = ERR;
            end
         end
         DONE: begin
            state_d = ENTRY;
         end
         ERR: begin
            if (k_clear) begin
               is_reg_d = 1'b1;
               dcnt_d   = 2'd0;
               pend_d   = OP_NONE;
               state_d  = ENTRY;
            end
         end
         default: begin
            state_d = ENTRY;
         end
      endcase

      busy_d  = (state_d == EXEC) || (state_d == WAIT_ALU);
      error_d = (state_d == ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ENTRY;
         pend_q         <= OP_NONE;
         dcnt_q         <= 2'd0;
         tcnt_q         <= 4'd0;
         store_digit_q  <= 1'b0;
         digit_q        <= 4'd0;
         is_reg_q       <= 1'b0;
         reg_sel_q      <= 3'd0;
         reg_wen_q      <= 1'b0;
         alu_op_q       <= 2'd0;
         alu_start_q    <= 1'b0;
         result_ready_q <= 1'b0;
         busy_q         <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         pend_q         <= pend_d;
         dcnt_q         <= dcnt_d;
         tcnt_q         <= tcnt_d;
         store_digit_q  <= store_digit_d;
         digit_q        <= digit_d;
         is_reg_q       <= is_reg_d;
         reg_sel_q      <= reg_sel_d;
         reg_wen_q      <= reg_wen_d;
         alu_op_q       <= alu_op_d;
         alu_start_q    <= alu_start_d;
         result_ready_q <= result_ready_d;
         busy_q         <= busy_d;
         error_q        <= error_d;
      end
   end

   assign bus.store_digit  = store_digit_q;
   assign bus.digit        = digit_q;
   assign bus.is_reg       = is_reg_q;
   assign bus.reg_sel      = reg_sel_q;
   assign bus.reg_wen      = reg_wen_q;
   assign bus.alu_op       = alu_op_q;
   assign bus.alu_start    = alu_start_q;
   assign bus.result_ready = result_ready_q;
   assign bus.busy         = busy_q;
   assign bus.error        = error_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: key sequences with hand-computed pulse expectations.
module tb_calc_sequencer;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   calc_sequencer_if bus ();

   calc_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned outs();
      return {16'd0, bus.store_digit, bus.digit, bus.is_reg, bus.reg_sel, bus.reg_wen,
              bus.alu_op, bus.alu_start, bus.result_ready, bus.busy, bus.error};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic key(input logic [4:0] code);
      bus.key_valid = 1'b1;
      bus.key_code  = code;
      @(negedge clk);
      bus.key_valid = 1'b0;
      bus.key_code  = 5'd0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      bus.key_valid = 1'b0;
      bus.key_code  = 5'd0;
      bus.alu_done  = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      chk("reset_outs", outs(), 0);
      rst = 1'b0;

      // Digit entry: two digits accepted, third dropped
      key(5'h03); chk("d3_store", bus.store_digit, 1); chk("d3_val", bus.digit, 3);
      key(5'h07); chk("d7_store", bus.store_digit, 1); chk("d7_val", bus.digit, 7);
      key(5'h09); chk("d9_drop", bus.store_digit, 0);
      key(5'h14); chk("clr_isreg", bus.is_reg, 1); chk("clr_store", bus.store_digit, 0);

      // LOAD into R2
      key(5'h05); chk("d5_store", bus.store_digit, 1); chk("d5_val", bus.digit, 5);
      key(5'h10); chk("load_quiet", {bus.store_digit, bus.is_reg, bus.reg_wen, bus.busy, bus.error}, 0);
      key(5'h1A); chk("r2_sel", bus.reg_sel, 2); chk("r2_wen", bus.reg_wen, 1);
      chk("r2_isreg", bus.is_reg, 1); chk("r2_store", bus.store_digit, 0);
      tick(); chk("r2_wen_pulse", bus.reg_wen, 0); chk("r2_sel_hold", bus.reg_sel, 2);

      // Stray alu_done in ENTRY
      bus.alu_done = 1'b1; tick(); bus.alu_done = 1'b0;
      chk("stray_done_rr", bus.result_ready, 0); chk("stray_done_busy", bus.busy, 0);

      // SUB with R4, ALU answers 3 cycles after start
      key(5'h12); chk("sub_op", bus.alu_op, 1); chk("sub_busy", bus.busy, 0);
      key(5'h1C); chk("r4_sel", bus.reg_sel, 4); chk("r4_busy", bus.busy, 1);
      chk("r4_nostart", bus.alu_start, 0);
      tick(); chk("start_pulse", bus.alu_start, 1); chk("start_busy", bus.busy, 1);
      key(5'h14); chk("exec_clr_ignored", bus.is_reg, 0); chk("start_once1", bus.alu_start, 0);
      chk("wait_busy1", bus.busy, 1);
      tick(); chk("start_once2", bus.alu_start, 0); chk("wait_busy2", bus.busy, 1);
      tick(); chk("start_once3", bus.alu_start, 0); chk("wait_busy3", bus.busy, 1);
      chk("no_early_rr", bus.result_ready, 0);
      bus.alu_done = 1'b1; tick(); bus.alu_done = 1'b0;
      chk("sub_rr", bus.result_ready, 1); chk("sub_rr_busy", bus.busy, 0);
      chk("sub_rr_isreg", bus.is_reg, 0); chk("sub_op_hold", bus.alu_op, 1);
      key(5'h08); chk("done_key_ignored", bus.store_digit, 0); chk("rr_pulse", bus.result_ready, 0);
      key(5'h08); chk("entry_d8", bus.store_digit, 1); chk("entry_d8_val", bus.digit, 8);
      key(5'h14);

      // ADD with R1, ALU never answers
      key(5'h11); chk("add_op", bus.alu_op, 0);
      key(5'h19); chk("r1_sel", bus.reg_sel, 1);
      tick(); chk("add_start", bus.alu_start, 1);
      repeat (14) tick();
      tick(); chk("to_err_not_yet", bus.error, 0); chk("to_busy_15", bus.busy, 1);
      tick(); chk("to_err", bus.error, 1); chk("to_busy_off", bus.busy, 0);
      key(5'h04); chk("err_digit_ignored", bus.store_digit, 0); chk("err_stays", bus.error, 1);
      key(5'h14); chk("err_clr_isreg", bus.is_reg, 1); chk("err_clr_err", bus.error, 0);

      // Digit while waiting for a register
      key(5'h11); key(5'h06); chk("waitreg_digit_err", bus.error, 1);
      key(5'h02); chk("err_d2_ignored", bus.store_digit, 0); chk("err_d2_err", bus.error, 1);
      key(5'h14); chk("rec_isreg", bus.is_reg, 1); chk("rec_err", bus.error, 0);
      key(5'h02); chk("rec_d2", bus.store_digit, 1); chk("rec_d2_val", bus.digit, 2);

      // Register key and illegal code in ENTRY
      key(5'h1B); chk("entry_reg_err", bus.error, 1);
      key(5'h14); chk("entry_reg_clr", bus.error, 0);
      key(5'h13); chk("illegal_err", bus.error, 1);
      key(5'h14); chk("illegal_clr", bus.error, 0);

      // Reset mid-WAIT_ALU colliding with alu_done
      key(5'h12); key(5'h1D); tick(); tick();
      chk("pre_rst_busy", bus.busy, 1);
      rst = 1'b1; bus.alu_done = 1'b1; tick(); rst = 1'b0; bus.alu_done = 1'b0;
      chk("rst_wait_outs", outs(), 0);
      tick(); chk("rst_no_late_rr", bus.result_ready, 0);
      key(5'h01); chk("post_rst_d1", bus.store_digit, 1); chk("post_rst_d1_val", bus.digit, 1);
      key(5'h02); chk("post_rst_d2", bus.store_digit, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have exactly one clock, one reset and the ports below, in this order.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high; sampled only on the rising edge of clk.
REQ-004 key_valid  in  1  one-cycle strobe; key_code is valid in that cycle.
REQ-005 key_code  in  5  0x00-0x0F digit; 0x10 LOAD; 0x11 ADD; 0x12 SUB; 0x14 CLEAR; 0x18-0x1F register R0-R7; all other codes are illegal.
REQ-006 alu_done  in  1  one-cycle strobe from the ALU when its result is valid.
REQ-007 store_digit  out  1  one-cycle pulse that shifts digit into the operand buffer.
REQ-008 digit  out  4  digit value, valid while store_digit=1.
REQ-009 is_reg  out  1  one-cycle pulse that clears the operand buffer and its display.
REQ-010 reg_sel  out  3  selected register index.
REQ-011 reg_wen  out  1  one-cycle pulse that writes the operand to register reg_sel.
REQ-012 alu_op  out  2  00 ADD, 01 SUB; held stable from alu_start until the result is returned.
REQ-013 alu_start  out  1  one-cycle pulse that starts the ALU.
REQ-014 result_ready  out  1  one-cycle pulse that latches the ALU result into the display.
REQ-015 busy  out  1  high in EXEC and WAIT_ALU.
REQ-016 error  out  1  high while the FSM is in ERR.

Function
REQ-017 FSM states SHALL be ENTRY, WAIT_REG, EXEC, WAIT_ALU, DONE and ERR.
REQ-018 All outputs SHALL be registered; each response SHALL appear in the cycle after the key_valid or alu_done that causes it.
REQ-019 ENTRY, digit key, digit count < 2: store_digit=1, digit=key_code[3:0], digit count +1, stay in ENTRY.
REQ-020 ENTRY, digit key, digit count = 2: key ignored, no output pulse, no state change.
REQ-021 ENTRY, LOAD/ADD/SUB: record the pending operation (alu_op for ADD/SUB), go to WAIT_REG; no output pulse.
REQ-022 ENTRY or WAIT_REG or ERR, CLEAR: is_reg=1, digit count=0, pending operation cancelled, go to ENTRY.
REQ-023 WAIT_REG, register key Rn, pending LOAD: reg_sel=n, reg_wen=1 and is_reg=1 in the same cycle, digit count=0, go to ENTRY.
REQ-024 WAIT_REG, register key Rn, pending ADD/SUB: reg_sel=n, go to EXEC.
REQ-025 EXEC: alu_start=1 for exactly one cycle, timeout counter=0, go to WAIT_ALU.
REQ-026 WAIT_ALU, alu_done: result_ready=1, digit count=0, go to DONE; is_reg SHALL NOT be asserted.
REQ-027 WAIT_ALU, no alu_done for 16 consecutive cycles: go to ERR; the 4-bit timeout counter wraps only through this exit.
REQ-028 DONE SHALL last one cycle, then go to ENTRY; a key arriving in DONE is ignored.
REQ-029 In EXEC and WAIT_ALU, every key including CLEAR SHALL be ignored.
REQ-030 WAIT_REG: a digit key, LOAD/ADD/SUB or illegal code SHALL send the FSM to ERR.
REQ-031 ENTRY: an illegal code or a register key SHALL send the FSM to ERR.
REQ-032 ERR: only CLEAR is accepted; all other keys are ignored.
REQ-033 alu_done outside WAIT_ALU SHALL be ignored.
REQ-034 reg_sel and alu_op SHALL hold their last value when not updated.
REQ-035 At most one of store_digit, is_reg or result_ready SHALL be high in any cycle.

Reset
REQ-036 rst=1 at a clock edge SHALL force ENTRY, digit count 0, timeout counter 0, pending operation none, and all outputs 0, from any state including mid-WAIT_ALU.
REQ-037 rst SHALL take priority over key_valid and alu_done in the same cycle.

Verification
REQ-038 Keys 3, 7, 9 -> store_digit pulses with digit=3, then digit=7; key 9 gives no pulse.
REQ-039 Keys 5, LOAD, R2 -> store_digit(5), then one cycle later reg_sel=2 with reg_wen=1 and is_reg=1.
REQ-040 Keys SUB, R4, then alu_done 3 cycles after alu_start -> alu_op=01, reg_sel=4, single alu_start, busy high until result_ready pulses, then ENTRY.
REQ-041 Keys ADD, R1 with alu_done withheld -> error=1 exactly 16 cycles after entering WAIT_ALU; CLEAR -> is_reg pulse, error=0.
REQ-042 Keys ADD, then digit 6 -> error=1; key 2 ignored; CLEAR -> recovery to ENTRY.
REQ-043 rst asserted in WAIT_ALU while alu_done arrives the same cycle -> no result_ready; all outputs 0 and ENTRY next cycle.
